router_in_port_voq: RTL and testbench
=====================================

// Module: router_in_port_voq
// PURPOSE
// - Receiving end of the next-tile FIFO-select tag: one router input port.
// - The upstream tile computes the output cardinal each request will take in this tile.
//   This block accepts the request plus that tag and pushes it into one of 5 per-output
//   virtual output queues (VOQs).
// - Per-VOQ full status goes back upstream for flow control.
// - Per-VOQ heads are presented to this tile's output arbiters, which pop with a grant.
// PARAMETERS
// - INPUT_CARDINAL  NULL_CARDINAL  side this port faces (NORTH/EAST/SOUTH/WEST/LOCAL)
// - DEPTH           4              entries per VOQ; power of 2, >=2
// - REQ_W           64             request width; tile id is in_req[31:24] ([31:28] col, [27:24] row)
// PORTS
// - clk               in   1            clock
// - rst               in   1            synchronous, active-high reset
// - local_tile_id     in   t_tile_id    this tile's id
// - in_req_valid      in   1            request present this cycle
// - in_req            in   REQ_W        request payload
// - in_req_next_card  in   t_cardinal   upstream-computed output cardinal for this tile
// - out_voq_full      out  5            [i]=1: VOQ i cannot accept (index N0 E1 S2 W3 L4)
// - out_req_valid     out  5            [i]=1: VOQ i head valid
// - out_req           out  5xREQ_W      VOQ heads
// - in_grant          in   5            [i]=1: arbiter pops VOQ i this cycle
// - err_sticky        out  1            sticky protocol-error flag
// BEHAVIOUR
// - Reset: all counts, pointers, out_req_valid, out_voq_full and err_sticky = 0.
//   out_req contents are don't-care while invalid.
//   Reset mid-operation discards every queued entry in the same cycle.
// - Push: occurs at the clk edge when in_req_valid && tag is legal && !out_voq_full[idx(tag)].
//   Mapping: NORTH->0, EAST->1, SOUTH->2, WEST->3, LOCAL->4.
// - Latency: a request pushed at edge N is visible on out_req_valid/out_req after edge N.
//   No same-cycle bypass.
// - Pop: occurs when in_grant[i] && out_req_valid[i]. The next entry (if any) is at the head
//   after that edge. in_grant[i] while empty is ignored and sets err_sticky.
// - Full: out_voq_full[i] = (count[i]==DEPTH), computed from the registered count only.
//   A pop in a cycle does NOT admit a push into a full VOQ in the same cycle.
// - Push while full: entry dropped, err_sticky set. Upstream must never do this.
// - Simultaneous push and pop on the same non-full VOQ: count unchanged; both pointers advance.
// - Different VOQs push/pop independently. Up to 1 push and 5 pops per cycle.
// - Pointers: log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits, range 0..DEPTH.
// - Illegal tag: err_sticky set and no push when any of these holds:
//   - tag is NULL_CARDINAL;
//   - tag == INPUT_CARDINAL and INPUT_CARDINAL != LOCAL (U-turn);
//   - tag is LOCAL and in_req[31:24] != local_tile_id.
// - err_sticky clears only on rst. Each error source also carries an `ASSERT with its own message.
// - FIFO order is preserved per VOQ. There is no ordering guarantee across VOQs.
// STRUCTURE
// - router_pkg additions:
//   - NUM_CARD=5;
//   - function card_to_voq_idx(t_cardinal)->logic[2:0];
//   - reuse t_cardinal and t_tile_id.
// - Sub-module router_voq_fifo #(DEPTH,REQ_W): single synchronous FIFO with push, pop, full,
//   empty, count and head. Instantiated 5 times in a generate loop.
// - Top level holds tag decode, legality checks, push demux, error flag and assertions.
// TESTING
// - Reset, then in_req_valid=1, tag=EAST, in_req[31:24]=8'h32, one cycle
//   -> next cycle out_req_valid=5'b00010, out_req[1] matches.
// - 4 pushes tag=SOUTH with no grants (DEPTH=4) -> out_voq_full[2]=1.
//   5th push -> dropped, err_sticky=1, VOQ still holds entries 1..4 in order.
// - VOQ[0] at count=2: push NORTH + in_grant[0] same cycle
//   -> count stays 2, head advances to entry 2, new entry at tail.
// - Full VOQ[3]: in_grant[3] and push WEST same cycle -> push refused, count=3 after edge.
// - local_tile_id=8'h22, tag=LOCAL, in_req[31:24]=8'h23 -> no push, err_sticky=1.
//   The same stimulus with 8'h22 -> push into VOQ[4].
// - INPUT_CARDINAL=WEST, tag=WEST -> err_sticky=1.
//   Separately: 3 entries queued, rst pulsed mid-stream -> out_req_valid=0 and out_voq_full=0
//   after the edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: cardinal directions, tile ids and the VOQ index mapping.
// Also provides the ASSERT macro used by router blocks (active only with ROUTER_ASSERT_ON).
package router_pkg;

    typedef enum logic [2:0] {
        NULL_CARDINAL = 3'd0,
        NORTH         = 3'd1,
        EAST          = 3'd2,
        SOUTH         = 3'd3,
        WEST          = 3'd4,
        LOCAL         = 3'd5
    } t_cardinal;

    typedef logic [7:0] t_tile_id;

    localparam int NUM_CARD = 5;

    // Index 7 marks "no VOQ"; callers treat it as an illegal tag.
    function automatic logic [2:0] card_to_voq_idx(input t_cardinal card);
        case (card)
            NORTH:   return 3'd0;
            EAST:    return 3'd1;
            SOUTH:   return 3'd2;
            WEST:    return 3'd3;
            LOCAL:   return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

endpackage

`ifndef ASSERT
`ifdef ROUTER_ASSERT_ON
`define ASSERT(lbl, prop, msg) lbl: assert property (@(posedge clk) disable iff (rst) (prop)) else $error(msg);
`else
`define ASSERT(lbl, prop, msg)
`endif
`endif

// File: rtl/router_voq_fifo.sv
// Single synchronous FIFO for one virtual output queue.
// Push is refused while full and pop while empty, both judged on the registered count.
module router_voq_fifo #(
    parameter int DEPTH = 4,
    parameter int REQ_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [REQ_W-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [REQ_W-1:0]             head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [REQ_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    // Head must be visible the cycle after the push, so the read is not pipelined.
    assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/router_in_port_voq.sv
// One router input port: decodes the upstream next-cardinal tag, checks legality and
// steers each request into one of five VOQs whose heads feed the output arbiters.
module router_in_port_voq
    import router_pkg::*;
#(
    parameter t_cardinal INPUT_CARDINAL = NULL_CARDINAL,
    parameter int        DEPTH          = 4,
    parameter int        REQ_W          = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  t_tile_id                           local_tile_id,
    input  logic                               in_req_valid,
    input  logic [REQ_W-1:0]                   in_req,
    input  t_cardinal                          in_req_next_card,
    output logic [NUM_CARD-1:0]                out_voq_full,
    output logic [NUM_CARD-1:0]                out_req_valid,
    output logic [NUM_CARD-1:0][REQ_W-1:0]     out_req,
    input  logic [NUM_CARD-1:0]                in_grant,
    output logic                               err_sticky
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [2:0]          tag_idx;
    logic                tag_null;
    logic                tag_uturn;
    logic                tag_bad_tile;
    logic                tag_legal;
    logic                illegal_req;
    logic [NUM_CARD-1:0] push_vec;
    logic [NUM_CARD-1:0] push_full_err;
    logic [NUM_CARD-1:0] pop_empty_err;
    logic [NUM_CARD-1:0] voq_empty;
    logic                err_sticky_reg;
    logic                err_sticky_next;

    always_comb begin
        tag_idx      = card_to_voq_idx(in_req_next_card);
        tag_null     = (in_req_next_card == NULL_CARDINAL) || (tag_idx == 3'd7);
        tag_uturn    = (in_req_next_card == INPUT_CARDINAL) && (INPUT_CARDINAL != LOCAL);
        tag_bad_tile = (in_req_next_card == LOCAL) && (in_req[31:24] != local_tile_id);
        tag_legal    = !(tag_null || tag_uturn || tag_bad_tile);
        illegal_req  = in_req_valid && !tag_legal;
    end

    generate
        for (genvar gi = 0; gi < NUM_CARD; gi++) begin : g_voq
            logic [CNT_W-1:0] voq_count;

            assign push_vec[gi]      = in_req_valid && tag_legal && (tag_idx == 3'(gi));
            assign push_full_err[gi] = push_vec[gi] && out_voq_full[gi];
            assign pop_empty_err[gi] = in_grant[gi] && voq_empty[gi];
            assign out_req_valid[gi] = (voq_count != '0);

            router_voq_fifo #(
                .DEPTH (DEPTH),
                .REQ_W (REQ_W)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push_vec[gi]),
                .push_data (in_req),
                .pop       (in_grant[gi]),
                .full      (out_voq_full[gi]),
                .empty     (voq_empty[gi]),
                .count     (voq_count),
                .head      (out_req[gi])
            );

            `ASSERT(a_push_full, !push_full_err[gi], "router_in_port_voq: push into full VOQ, entry dropped")
            `ASSERT(a_pop_empty, !pop_empty_err[gi], "router_in_port_voq: grant on empty VOQ")
        end
    endgenerate

    `ASSERT(a_tag_legal, !illegal_req, "router_in_port_voq: illegal next-cardinal tag (null, U-turn or foreign LOCAL)")

    always_comb begin
        err_sticky_next = err_sticky_reg;
        if (illegal_req || (|push_full_err) || (|pop_empty_err)) err_sticky_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_sticky_reg <= 1'b0;
        else     err_sticky_reg <= err_sticky_next;
    end

    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_router_in_port_voq.sv
// Scoreboard bench for router_in_port_voq: per-VOQ expected queues filled on push,
// drained and compared as heads are granted.
module tb_router_in_port_voq;
    import router_pkg::*;

    localparam int DEPTH = 4;
    localparam int REQ_W = 64;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    t_tile_id                          local_tile_id = 8'h22;
    logic                              in_req_valid = 1'b0;
    logic [REQ_W-1:0]                  in_req = '0;
    t_cardinal                         in_req_next_card = NULL_CARDINAL;
    logic [NUM_CARD-1:0]               in_grant = '0;
    logic [NUM_CARD-1:0]               out_voq_full;
    logic [NUM_CARD-1:0]               out_req_valid;
    logic [NUM_CARD-1:0][REQ_W-1:0]    out_req;
    logic                              err_sticky;
    logic [NUM_CARD-1:0]               w_voq_full;
    logic [NUM_CARD-1:0]               w_req_valid;
    logic [NUM_CARD-1:0][REQ_W-1:0]    w_req;
    logic                              w_err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    logic [REQ_W-1:0] q [NUM_CARD][$];
    logic             exp_err = 1'b0;

    always #5 clk = ~clk;

    router_in_port_voq #(.INPUT_CARDINAL(LOCAL), .DEPTH(DEPTH), .REQ_W(REQ_W)) dut (
        .clk(clk), .rst(rst), .local_tile_id(local_tile_id),
        .in_req_valid(in_req_valid), .in_req(in_req), .in_req_next_card(in_req_next_card),
        .out_voq_full(out_voq_full), .out_req_valid(out_req_valid), .out_req(out_req),
        .in_grant(in_grant), .err_sticky(err_sticky)
    );

    router_in_port_voq #(.INPUT_CARDINAL(WEST), .DEPTH(DEPTH), .REQ_W(REQ_W)) dut_w (
        .clk(clk), .rst(rst), .local_tile_id(local_tile_id),
        .in_req_valid(in_req_valid), .in_req(in_req), .in_req_next_card(in_req_next_card),
        .out_voq_full(w_voq_full), .out_req_valid(w_req_valid), .out_req(w_req),
        .in_grant(in_grant), .err_sticky(w_err_sticky)
    );

    function automatic int tb_idx(input t_cardinal tag);
        case (tag)
            NORTH:   return 0;
            EAST:    return 1;
            SOUTH:   return 2;
            WEST:    return 3;
            default: return 4;
        endcase
    endfunction

    // Legality for the main DUT, which faces LOCAL (so no U-turn restriction applies).
    function automatic bit tb_legal(input t_cardinal tag, input logic [REQ_W-1:0] req);
        case (tag)
            NORTH, EAST, SOUTH, WEST: return 1'b1;
            LOCAL:                    return req[31:24] == local_tile_id;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic [REQ_W-1:0] mk_req(input t_tile_id id, input int seq);
        return {32'(seq) ^ 32'hC0DE_0000, id, 24'(seq)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_CARD; i++) q[i].delete();
        exp_err = 1'b0;
    endtask

    // One clock of stimulus; updates the model queues as the DUT should behave at the edge.
    task automatic drive(input bit v, input t_cardinal tag, input logic [REQ_W-1:0] req,
                         input logic [NUM_CARD-1:0] g);
        int idx;
        bit do_push;
        logic [NUM_CARD-1:0] do_pop;
        in_req_valid = v; in_req_next_card = tag; in_req = req; in_grant = g;
        do_push = 1'b0; do_pop = '0; idx = tb_idx(tag);
        for (int i = 0; i < NUM_CARD; i++)
            if (g[i]) begin
                if (q[i].size() > 0) do_pop[i] = 1'b1;
                else exp_err = 1'b1;
            end
        if (v) begin
            if (!tb_legal(tag, req)) exp_err = 1'b1;
            else if (q[idx].size() == DEPTH) exp_err = 1'b1;
            else do_push = 1'b1;
        end
        $display("[TB] t=%0t valid=%0b tag=%s req=%h grant=%b", $time, v, tag.name(), req, g);
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CARD; i++) if (do_pop[i]) void'(q[i].pop_front());
        if (do_push) q[idx].push_back(req);
        in_req_valid = 1'b0; in_grant = '0; in_req_next_card = NULL_CARDINAL;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_req_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 00000", out_req_valid); end
        n_tests++; if (out_voq_full !== 5'b0) begin n_fail++; $display("FAIL reset_full: got %b want 00000", out_voq_full); end
        n_tests++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_sticky); end
        do_reset();
    endtask

    task automatic test_single_push();
        logic [REQ_W-1:0] r;
        r = mk_req(8'h32, 1);
        in_req_valid = 1'b1; in_req_next_card = EAST; in_req = r;
        @(negedge clk);
        n_tests++; if (out_req_valid !== 5'b0) begin n_fail++; $display("FAIL no_bypass: got %b want 00000", out_req_valid); end
        drive(1'b1, EAST, r, '0);
        n_tests++; if (out_req_valid !== 5'b00010) begin n_fail++; $display("FAIL single_valid: got %b want 00010", out_req_valid); end
        n_tests++; if (out_req[1] !== q[1][0]) begin n_fail++; $display("FAIL single_data: got %h want %h", out_req[1], q[1][0]); end
        drive(1'b0, NULL_CARDINAL, '0, 5'b00010);
        n_tests++; if (out_req_valid !== 5'b0) begin n_fail++; $display("FAIL single_pop: got %b want 00000", out_req_valid); end
    endtask

    task automatic test_full_south();
        for (int k = 1; k <= DEPTH; k++) drive(1'b1, SOUTH, mk_req(8'h40, 16 + k), '0);
        n_tests++; if (out_voq_full !== 5'b00100) begin n_fail++; $display("FAIL south_full: got %b want 00100", out_voq_full); end
        n_tests++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL south_err_before: got %b want 0", err_sticky); end
        drive(1'b1, SOUTH, mk_req(8'h40, 99), '0);
        n_tests++; if (err_sticky !== exp_err || exp_err !== 1'b1) begin n_fail++; $display("FAIL south_drop_err: got %b want 1", err_sticky); end
        n_tests++; if (q[2].size() != DEPTH) begin n_fail++; $display("FAIL south_model_size: got %0d want %0d", q[2].size(), DEPTH); end
        while (q[2].size() > 0) begin
            n_tests++; if (out_req[2] !== q[2][0]) begin n_fail++; $display("FAIL south_order: got %h want %h", out_req[2], q[2][0]); end
            drive(1'b0, NULL_CARDINAL, '0, 5'b00100);
        end
        n_tests++; if (out_req_valid[2] !== 1'b0) begin n_fail++; $display("FAIL south_drained: got %b want 0", out_req_valid[2]); end
        do_reset();
    endtask

    task automatic test_simul_north();
        drive(1'b1, NORTH, mk_req(8'h50, 1), '0);
        drive(1'b1, NORTH, mk_req(8'h50, 2), '0);
        drive(1'b1, NORTH, mk_req(8'h50, 3), 5'b00001);
        n_tests++; if (out_req[0] !== mk_req(8'h50, 2)) begin n_fail++; $display("FAIL simul_head: got %h want %h", out_req[0], mk_req(8'h50, 2)); end
        n_tests++; if (out_voq_full[0] !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL simul_flags: got full=%b err=%b want 0 0", out_voq_full[0], err_sticky); end
        drive(1'b0, NULL_CARDINAL, '0, 5'b00001);
        n_tests++; if (out_req[0] !== mk_req(8'h50, 3) || out_req[0] !== q[0][0]) begin n_fail++; $display("FAIL simul_tail: got %h want %h", out_req[0], mk_req(8'h50, 3)); end
        drive(1'b0, NULL_CARDINAL, '0, 5'b00001);
        n_tests++; if (out_req_valid[0] !== 1'b0) begin n_fail++; $display("FAIL simul_count2: got valid %b want 0", out_req_valid[0]); end
    endtask

    task automatic test_full_west_pop();
        for (int k = 1; k <= DEPTH; k++) drive(1'b1, WEST, mk_req(8'h60, k), '0);
        drive(1'b1, WEST, mk_req(8'h60, 5), 5'b01000);
        n_tests++; if (out_voq_full[3] !== 1'b0 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL west_refuse: got full=%b err=%b want 0 1", out_voq_full[3], err_sticky); end
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (out_req_valid[3] !== 1'b1 || out_req[3] !== q[3][0]) begin n_fail++; $display("FAIL west_drain%0d: got %b/%h want 1/%h", k, out_req_valid[3], out_req[3], q[3][0]); end
            drive(1'b0, NULL_CARDINAL, '0, 5'b01000);
        end
        n_tests++; if (out_req_valid[3] !== 1'b0) begin n_fail++; $display("FAIL west_count3: got valid %b want 0", out_req_valid[3]); end
        do_reset();
    endtask

    task automatic test_local();
        drive(1'b1, LOCAL, mk_req(8'h23, 7), '0);
        n_tests++; if (out_req_valid[4] !== 1'b0 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL local_foreign: got valid=%b err=%b want 0 1", out_req_valid[4], err_sticky); end
        do_reset();
        drive(1'b1, LOCAL, mk_req(8'h22, 8), '0);
        n_tests++; if (out_req_valid !== 5'b10000 || out_req[4] !== mk_req(8'h22, 8) || err_sticky !== 1'b0) begin n_fail++; $display("FAIL local_own: got valid=%b data=%h err=%b want 10000 %h 0", out_req_valid, out_req[4], err_sticky, mk_req(8'h22, 8)); end
        do_reset();
    endtask

    task automatic test_uturn();
        drive(1'b1, WEST, mk_req(8'h11, 9), '0);
        n_tests++; if (w_err_sticky !== 1'b1 || w_req_valid !== 5'b0) begin n_fail++; $display("FAIL uturn_west: got err=%b valid=%b want 1 00000", w_err_sticky, w_req_valid); end
        n_tests++; if (err_sticky !== 1'b0 || out_req_valid !== 5'b01000) begin n_fail++; $display("FAIL uturn_local_port: got err=%b valid=%b want 0 01000", err_sticky, out_req_valid); end
        do_reset();
        drive(1'b1, NULL_CARDINAL, mk_req(8'h11, 10), '0);
        n_tests++; if (err_sticky !== 1'b1 || out_req_valid !== 5'b0) begin n_fail++; $display("FAIL null_tag: got err=%b valid=%b want 1 00000", err_sticky, out_req_valid); end
        do_reset();
        drive(1'b0, NULL_CARDINAL, '0, 5'b00100);
        n_tests++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL grant_empty: got err=%b want 1", err_sticky); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) drive(1'b1, SOUTH, mk_req(8'h70, k), '0);
        for (int k = 0; k < DEPTH; k++) drive(1'b1, EAST, mk_req(8'h71, k), '0);
        n_tests++; if (out_voq_full !== 5'b00010 || out_req_valid !== 5'b00110) begin n_fail++; $display("FAIL mid_setup: got full=%b valid=%b want 00010 00110", out_voq_full, out_req_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_req_valid !== 5'b0 || out_voq_full !== 5'b0) begin n_fail++; $display("FAIL mid_reset: got valid=%b full=%b want 00000 00000", out_req_valid, out_voq_full); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        t_cardinal tags [5];
        logic [NUM_CARD-1:0] exp_valid, exp_full, g;
        t_cardinal tag;
        logic [REQ_W-1:0] r;
        bit v;
        tags[0] = NORTH; tags[1] = EAST; tags[2] = SOUTH; tags[3] = WEST; tags[4] = LOCAL;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_CARD; i++) begin
                exp_valid[i] = q[i].size() > 0;
                exp_full[i]  = q[i].size() == DEPTH;
            end
            n_tests++; if (out_req_valid !== exp_valid || out_voq_full !== exp_full) begin n_fail++; $display("FAIL b2b_status c=%0d: got valid=%b full=%b want %b %b", c, out_req_valid, out_voq_full, exp_valid, exp_full); end
            tag = tags[$urandom_range(0, 4)];
            r = mk_req((tag == LOCAL) ? local_tile_id : t_tile_id'($urandom), 1000 + c);
            v = ($urandom_range(0, 3) != 0) && (q[tb_idx(tag)].size() < DEPTH);
            g = '0;
            for (int i = 0; i < NUM_CARD; i++)
                if (exp_valid[i] && $urandom_range(0, 2) == 0) begin
                    g[i] = 1'b1;
                    n_tests++; if (out_req[i] !== q[i][0]) begin n_fail++; $display("FAIL b2b_head c=%0d voq=%0d: got %h want %h", c, i, out_req[i], q[i][0]); end
                end
            drive(v, tag, r, g);
        end
        n_tests++; if (err_sticky !== exp_err) begin n_fail++; $display("FAIL b2b_err: got %b want %b", err_sticky, exp_err); end
        do_reset();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_push();
        test_full_south();
        test_simul_north();
        test_full_west_pop();
        test_local();
        test_uturn();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
